// File: rtl/mem_ldbuf_pkg.sv
// Shared types for the memory-stage load-response buffer.
package mem_ldbuf_pkg;

    // Widest byte offset supported (DATA_W = 64 -> 3 bits).
    localparam int unsigned LDBUF_OFF_W = 3;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ent_state_e;

    // Width-independent part of an entry; tag and data live in
    // parameter-sized arrays in the buffer itself.
    typedef struct packed {
        ent_state_e             state;
        ld_size_e               size;
        logic                   sign;
        logic [LDBUF_OFF_W-1:0] off;
    } ld_meta_t;

endpackage

// File: rtl/load_align.sv
// Lane selection and sign/zero extension of raw load data.
module load_align
    import mem_ldbuf_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]            data_i,
    input  ld_size_e                     size_i,
    input  logic                         sign_i,
    input  logic [$clog2(DATA_W/8)-1:0]  off_i,
    output logic [DATA_W-1:0]            data_o
);
    localparam int unsigned OW = $clog2(DATA_W/8);
    localparam int unsigned SW = $clog2(DATA_W);

    logic [SW-1:0]     shamt;
    logic [DATA_W-1:0] ones, mask, sh;
    logic              msb;

    // Shift the addressed lane down to bit 0, then mask and extend.
    always_comb begin
        ones  = '1;
        shamt = '0;
        mask  = ones;
        case (size_i)
            LD_B: begin
                shamt = {off_i, 3'b000};
                mask  = ones >> (DATA_W - 8);
            end
            LD_H: begin
                shamt = {off_i[OW-1:1], 4'b0000};
                mask  = ones >> (DATA_W - 16);
            end
            LD_W: begin
                shamt = (DATA_W == 64) ? SW'({off_i[OW-1], 5'b00000}) : '0;
                mask  = ones >> (DATA_W - 32);
            end
            default: begin
                shamt = '0;
                mask  = ones;
            end
        endcase
        sh = data_i >> shamt;
        case (size_i)
            LD_B:    msb = sh[7];
            LD_H:    msb = sh[15];
            LD_W:    msb = sh[31];
            default: msb = sh[DATA_W-1];
        endcase
        data_o = (sh & mask) | ((sign_i && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_load_buffer.sv
// In-order load-response buffer between dcache and writeback.
// Optional: MEM_LDBUF_BYPASS_EN forwards a head response in the same cycle.
module mem_load_buffer
    import mem_ldbuf_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_size,
    input  logic                          req_sign,
    input  logic [$clog2(DATA_W/8)-1:0]   req_off,
    input  logic [TAG_W-1:0]              req_tag,
    input  logic                          rsp_valid,
    input  logic [DATA_W-1:0]             rsp_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [TAG_W-1:0]              out_tag,
    input  logic                          flush,
    output logic                          busy,
    output logic [$clog2(DEPTH+1)-1:0]    outstanding,
    output logic                          err_unexp
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(DATA_W / 8);
`ifdef MEM_LDBUF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    ld_meta_t          meta_q [DEPTH];
    ld_meta_t          meta_d [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, rsp_q, rsp_d;
    logic [CW-1:0]     count_q, count_d, wait_q, wait_d, drop_q, drop_d;
    logic              err_q, err_d;
    logic [CW:0]       occ;
    logic              accept, rsp_drop, rsp_hit, rsp_unexp, byp_hit, fire;
    ld_meta_t          head_meta;
    logic [DATA_W-1:0] align_src;

    assign head_meta = meta_q[head_q];
    assign occ       = {1'b0, count_q} + {1'b0, drop_q};
    assign req_ready = !flush && (occ < (CW+1)'(DEPTH));
    assign accept    = req_valid && req_ready;
    // Responses owed to flushed loads are swallowed before anything else.
    assign rsp_drop  = rsp_valid && (drop_q != '0);
    assign rsp_hit   = rsp_valid && (drop_q == '0) && (wait_q != '0);
    assign rsp_unexp = rsp_valid && (drop_q == '0) && (wait_q == '0);
    // Oldest WAIT entry sits at the head only when nothing is DONE ahead of it.
    assign byp_hit   = BYPASS && rsp_hit && (rsp_q == head_q);
    assign out_valid = !flush && ((head_meta.state == DONE) || byp_hit);
    assign fire      = out_valid && out_ready;
    assign align_src = byp_hit ? rsp_data : data_q[head_q];

    assign out_tag     = tag_q[head_q];
    assign busy        = (outstanding != '0);
    assign outstanding = wait_q + drop_q;
    assign err_unexp   = err_q;

    load_align #(.DATA_W(DATA_W)) u_align (
        .data_i (align_src),
        .size_i (head_meta.size),
        .sign_i (head_meta.sign),
        .off_i  (head_meta.off[OW-1:0]),
        .data_o (out_data)
    );

    // Next-state for entry states, pointers and counters.
    always_comb begin
        meta_d  = meta_q;
        head_d  = head_q;
        tail_d  = tail_q;
        rsp_d   = rsp_q;
        count_d = count_q;
        wait_d  = wait_q;
        drop_d  = drop_q;
        err_d   = err_q | rsp_unexp;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                meta_d[i].state = FREE;
            end
            head_d  = '0;
            tail_d  = '0;
            rsp_d   = '0;
            count_d = '0;
            wait_d  = '0;
            // Every load still waiting on the cache now owes one discard.
            drop_d  = drop_q + wait_q - CW'(rsp_drop || rsp_hit);
        end else begin
            if (accept) begin
                meta_d[tail_q] = '{state: WAIT, size: ld_size_e'(req_size),
                                   sign: req_sign, off: LDBUF_OFF_W'(req_off)};
                tail_d = tail_q + PW'(1);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_hit) begin
                meta_d[rsp_q].state = DONE;
                rsp_d = rsp_q + PW'(1);
            end
            // Placed after the response so a bypassed head goes straight to FREE.
            if (fire) begin
                meta_d[head_q].state = FREE;
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(accept) - CW'(fire);
            wait_d  = wait_q + CW'(accept) - CW'(rsp_hit);
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                meta_q[i] <= '{state: FREE, size: LD_B, sign: 1'b0, off: '0};
            end
            head_q  <= '0;
            tail_q  <= '0;
            rsp_q   <= '0;
            count_q <= '0;
            wait_q  <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rsp_q   <= rsp_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    // Payload storage; only meaningful while the entry state says so.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q[tail_q] <= req_tag;
        end
        if (rsp_hit) begin
            data_q[rsp_q] <= rsp_data;
        end
    end

endmodule
